// File: rtl/sevenseg_scan_capture.sv
// sevenseg_scan_capture
//   Receive-side decoder for a multiplexed, active-low 4-digit 7-segment bus.
//   It watches the anode/segment lines as they scan, samples each digit once
//   its anode has been steady for SETTLE_CYCLES, decodes the segment pattern
//   back to a 4-bit code, and publishes complete 4-digit frames. The frame is
//   also offered as binary minutes/seconds (MM:SS).
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   an[3:0]      anode bus, active-low one-hot (an[3] = leftmost digit)
//   seg[6:0]     segment bus, active-low (seg[0]=a ... seg[6]=g)
//   digits       last complete frame, [15:12] = an[3] digit
//   frame_valid  digits holds a frame and the scan has not been lost
//   frame_stb    one-cycle pulse when digits is updated
//   minutes_bin  digits[15:12]*10 + digits[11:8], 7'h7F if not BCD
//   seconds_bin  digits[7:4]*10 + digits[3:0], 7'h7F if not BCD
//   err_pattern  one-cycle pulse on an undecodable sampled pattern
//   err_timeout  level, no successful capture for TIMEOUT_CYCLES
module sevenseg_scan_capture #(
  parameter int SETTLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        frame_stb,
  output logic [6:0]  minutes_bin,
  output logic [6:0]  seconds_bin,
  output logic        err_pattern,
  output logic        err_timeout
);

  // Settle counter saturates at SETTLE_CYCLES so the capture value
  // SETTLE_CYCLES-1 is passed exactly once per dwell.
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_SAT  = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]    an_meta_reg, an_s_reg, an_prev_reg;
  logic [6:0]    seg_meta_reg, seg_s_reg;
  logic [SW-1:0] settle_cnt_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic [3:0]    mask_reg;
  logic [15:0]   shadow_reg;
  logic [15:0]   digits_reg;
  logic          frame_valid_reg, frame_stb_reg;
  logic [6:0]    minutes_reg, seconds_reg;
  logic          err_pattern_reg, err_timeout_reg;

  logic          an_legal, an_stable, capture;
  logic [3:0]    slot_oh;
  logic [3:0]    code;
  logic          code_ok;
  logic [15:0]   shadow_next;
  logic [3:0]    mask_next;
  logic          frame_done;

  // BCD pair to binary; x*10 = x*8 + x*2 keeps everything within 7 bits.
  function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
    logic [6:0] r;
    if (tens > 4'd9 || ones > 4'd9) begin
      r = 7'h7F;
    end else begin
      r = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, ones};
    end
    return r;
  endfunction

  // Exactly one anode low.
  always_comb begin
    an_legal = 1'b0;
    case (an_s_reg)
      4'b0111, 4'b1011, 4'b1101, 4'b1110: an_legal = 1'b1;
      default:                            an_legal = 1'b0;
    endcase
  end

  assign an_stable = (an_s_reg == an_prev_reg);
  assign capture   = an_legal && an_stable && (settle_cnt_reg == SETTLE_LAST);
  assign slot_oh   = ~an_s_reg;

  // Segment pattern (g..a, active-low) back to digit code.
  always_comb begin
    code    = 4'h0;
    code_ok = 1'b1;
    case (seg_s_reg)
      7'b1000000: code = 4'h0;
      7'b1111001: code = 4'h1;
      7'b0100100: code = 4'h2;
      7'b0110000: code = 4'h3;
      7'b0011001: code = 4'h4;
      7'b0010010: code = 4'h5;
      7'b0000010: code = 4'h6;
      7'b1111000: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0010000: code = 4'h9;
      7'b0001000: code = 4'hA;
      7'b0000011: code = 4'hB;
      7'b1000110: code = 4'hC;
      7'b0100001: code = 4'hD;
      7'b0101011: code = 4'hE;
      7'b1111111: code = 4'hF;
      default:    code_ok = 1'b0;
    endcase
  end

  // Shadow frame with the newly decoded code dropped into the active slot.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      assign shadow_next[gi*4 +: 4] = slot_oh[gi] ? code : shadow_reg[gi*4 +: 4];
    end
  endgenerate

  assign mask_next  = mask_reg | slot_oh;
  assign frame_done = capture && code_ok && (mask_next == 4'b1111);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Sync stages reset to the idle bus (all anodes and segments off).
      an_meta_reg     <= 4'hF;
      an_s_reg        <= 4'hF;
      an_prev_reg     <= 4'hF;
      seg_meta_reg    <= 7'h7F;
      seg_s_reg       <= 7'h7F;
      settle_cnt_reg  <= '0;
      tmo_cnt_reg     <= '0;
      mask_reg        <= 4'b0000;
      shadow_reg      <= 16'hFFFF;
      digits_reg      <= 16'hFFFF;
      frame_valid_reg <= 1'b0;
      frame_stb_reg   <= 1'b0;
      minutes_reg     <= 7'h7F;
      seconds_reg     <= 7'h7F;
      err_pattern_reg <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      an_meta_reg  <= an;
      an_s_reg     <= an_meta_reg;
      an_prev_reg  <= an_s_reg;
      seg_meta_reg <= seg;
      seg_s_reg    <= seg_meta_reg;

      frame_stb_reg   <= 1'b0;
      err_pattern_reg <= 1'b0;

      if (!an_stable || !an_legal) begin
        settle_cnt_reg <= '0;
      end else if (settle_cnt_reg != SETTLE_SAT) begin
        settle_cnt_reg <= settle_cnt_reg + SW'(1);
      end

      // A capture in the terminal-count cycle suppresses the timeout.
      if (capture) begin
        tmo_cnt_reg <= '0;
        if (code_ok) begin
          shadow_reg      <= shadow_next;
          err_timeout_reg <= 1'b0;
          if (frame_done) begin
            digits_reg      <= shadow_next;
            minutes_reg     <= bcd2bin(shadow_next[15:12], shadow_next[11:8]);
            seconds_reg     <= bcd2bin(shadow_next[7:4], shadow_next[3:0]);
            frame_stb_reg   <= 1'b1;
            frame_valid_reg <= 1'b1;
            mask_reg        <= 4'b0000;
          end else begin
            mask_reg <= mask_next;
          end
        end else begin
          err_pattern_reg <= 1'b1;
          mask_reg        <= mask_reg & an_s_reg;
        end
      end else if (tmo_cnt_reg == TMO_LAST) begin
        // Counter parks at its terminal value; the lost state holds until
        // the next legal capture.
        err_timeout_reg <= 1'b1;
        frame_valid_reg <= 1'b0;
        mask_reg        <= 4'b0000;
      end else begin
        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
      end
    end
  end

  assign digits      = digits_reg;
  assign frame_valid = frame_valid_reg;
  assign frame_stb   = frame_stb_reg;
  assign minutes_bin = minutes_reg;
  assign seconds_bin = seconds_reg;
  assign err_pattern = err_pattern_reg;
  assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_sevenseg_scan_capture.sv
// Bench for sevenseg_scan_capture (SETTLE_CYCLES=4, TIMEOUT_CYCLES=64).
// A dwell-based model predicts captures from the history of applied anode
// values; outputs are compared on every falling edge, with literal
// expectations for the directed scenarios.
module tb_sevenseg_scan_capture;

  localparam int S = 4;
  localparam int T = 64;
  localparam int H = S + 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic        frame_valid, frame_stb, err_pattern, err_timeout;
  logic [6:0]  minutes_bin, seconds_bin;

  sevenseg_scan_capture #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
    .digits(digits), .frame_valid(frame_valid), .frame_stb(frame_stb),
    .minutes_bin(minutes_bin), .seconds_bin(seconds_bin),
    .err_pattern(err_pattern), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  logic [6:0] pat_tab [16];
  initial begin
    pat_tab[0]  = 7'b1000000; pat_tab[1]  = 7'b1111001; pat_tab[2]  = 7'b0100100;
    pat_tab[3]  = 7'b0110000; pat_tab[4]  = 7'b0011001; pat_tab[5]  = 7'b0010010;
    pat_tab[6]  = 7'b0000010; pat_tab[7]  = 7'b1111000; pat_tab[8]  = 7'b0000000;
    pat_tab[9]  = 7'b0010000; pat_tab[10] = 7'b0001000; pat_tab[11] = 7'b0000011;
    pat_tab[12] = 7'b1000110; pat_tab[13] = 7'b0100001; pat_tab[14] = 7'b0101011;
    pat_tab[15] = 7'b1111111;
  end

  // ---------------- behavioural model ----------------
  logic [3:0]  hist_an  [H];
  logic [6:0]  hist_seg [H];
  logic [15:0] m_shadow, m_digits;
  logic [3:0]  m_mask;
  logic        m_fv, m_stb, m_errp, m_errt;
  int          idle_run;
  bit          m_ready = 1'b0;

  function automatic int zero_count(input logic [3:0] a);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) n++;
    return n;
  endfunction

  function automatic logic [6:0] to_bin(input logic [3:0] t, input logic [3:0] o);
    int v;
    if (t > 9 || o > 9) return 7'h7F;
    v = t * 10 + o;
    return 7'(v);
  endfunction

  always @(posedge clk) begin
    bit cap, found;
    int slot, code;
    for (int i = H - 1; i > 0; i--) begin
      hist_an[i]  = hist_an[i-1];
      hist_seg[i] = hist_seg[i-1];
    end
    hist_an[0]  = an;
    hist_seg[0] = seg;
    m_stb  = 1'b0;
    m_errp = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < H; i++) begin
        hist_an[i]  = 4'hF;
        hist_seg[i] = 7'h7F;
      end
      m_mask = 4'b0; m_shadow = 16'hFFFF; m_digits = 16'hFFFF;
      m_fv = 1'b0; m_errt = 1'b0; idle_run = 0;
    end else begin
      // Capture when the synchronized anode (two edges old) is legal and
      // its run has lasted exactly S+1 cycles.
      cap = (zero_count(hist_an[2]) == 1) && (hist_an[S+3] != hist_an[2]);
      for (int j = 0; j <= S; j++) if (hist_an[2+j] != hist_an[2]) cap = 1'b0;
      if (cap) begin
        idle_run = 0;
        slot = 0;
        for (int i = 0; i < 4; i++) if (!hist_an[2][i]) slot = i;
        found = 1'b0; code = 0;
        for (int c = 0; c < 16; c++) if (pat_tab[c] == hist_seg[2]) begin found = 1'b1; code = c; end
        if (found) begin
          m_shadow[slot*4 +: 4] = 4'(code);
          m_mask[slot] = 1'b1;
          m_errt = 1'b0;
          if (m_mask == 4'hF) begin
            m_digits = m_shadow; m_stb = 1'b1; m_fv = 1'b1; m_mask = 4'b0;
          end
        end else begin
          m_errp = 1'b1;
          m_mask[slot] = 1'b0;
        end
      end else begin
        idle_run++;
        if (idle_run >= T) begin
          m_errt = 1'b1; m_fv = 1'b0; m_mask = 4'b0;
        end
      end
    end
    m_ready = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  int stb_cnt = 0, errp_cnt = 0;
  always @(negedge clk) begin
    if (frame_stb === 1'b1) stb_cnt++;
    if (err_pattern === 1'b1) errp_cnt++;
    if (m_ready) begin
      chk("digits", digits, m_digits);
      chk("frame_valid", {15'b0, frame_valid}, {15'b0, m_fv});
      chk("frame_stb", {15'b0, frame_stb}, {15'b0, m_stb});
      chk("minutes_bin", {9'b0, minutes_bin}, {9'b0, to_bin(m_digits[15:12], m_digits[11:8])});
      chk("seconds_bin", {9'b0, seconds_bin}, {9'b0, to_bin(m_digits[7:4], m_digits[3:0])});
      chk("err_pattern", {15'b0, err_pattern}, {15'b0, m_errp});
      chk("err_timeout", {15'b0, err_timeout}, {15'b0, m_errt});
    end
  end

  // ---------------- stimulus ----------------
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a; seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_round(input int d3, input int d2, input int d1, input int d0, input int n);
    dwell(4'b0111, pat_tab[d3], n);
    dwell(4'b1011, pat_tab[d2], n);
    dwell(4'b1101, pat_tab[d1], n);
    dwell(4'b1110, pat_tab[d0], n);
  endtask

  initial begin
    int base_stb, base_errp;
    rst_n = 1'b0; an = 4'hF; seg = 7'h7F;
    // Reset with toggling inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      an = 4'($urandom); seg = 7'($urandom);
    end
    chk("rst digits", digits, 16'hFFFF);
    chk("rst minutes", {9'b0, minutes_bin}, 16'h007F);
    chk("rst seconds", {9'b0, seconds_bin}, 16'h007F);
    chk("rst flags", {12'b0, frame_valid, frame_stb, err_pattern, err_timeout}, 16'h0);
    rst_n = 1'b1;

    // Normal 12:34 scan.
    base_stb = stb_cnt;
    for (int r = 0; r < 3; r++) scan_round(1, 2, 3, 4, 10);
    dwell(4'hF, 7'h7F, 10);
    chk("normal stb count", 16'(stb_cnt - base_stb), 16'd3);
    chk("normal digits", digits, 16'h1234);
    chk("normal minutes", {9'b0, minutes_bin}, 16'd12);
    chk("normal seconds", {9'b0, seconds_bin}, 16'd34);
    chk("normal valid", {15'b0, frame_valid}, 16'd1);

    // Short glitch dwell on an[2] showing 9.
    dwell(4'b1011, pat_tab[9], 3);
    scan_round(1, 2, 3, 4, 10);
    dwell(4'hF, 7'h7F, 8);
    chk("glitch digits", digits, 16'h1234);

    // Undecodable pattern on an[1].
    base_stb = stb_cnt; base_errp = errp_cnt;
    dwell(4'b0111, pat_tab[1], 10);
    dwell(4'b1011, pat_tab[2], 10);
    dwell(4'b1101, 7'b1010101, 10);
    dwell(4'b1110, pat_tab[4], 10);
    dwell(4'hF, 7'h7F, 8);
    chk("badpat errp count", 16'(errp_cnt - base_errp), 16'd1);
    chk("badpat stb count", 16'(stb_cnt - base_stb), 16'd0);
    scan_round(1, 2, 3, 4, 10);

    // Scan loss, then resume 05:09.
    dwell(4'hF, 7'h7F, 70);
    chk("loss timeout", {15'b0, err_timeout}, 16'd1);
    chk("loss valid", {15'b0, frame_valid}, 16'd0);
    chk("loss digits", digits, 16'h1234);
    dwell(4'b0111, pat_tab[0], 10);
    chk("resume timeout clear", {15'b0, err_timeout}, 16'd0);
    dwell(4'b1011, pat_tab[5], 10);
    dwell(4'b1101, pat_tab[0], 10);
    dwell(4'b1110, pat_tab[9], 10);
    scan_round(0, 5, 0, 9, 10);
    chk("resume digits", digits, 16'h0509);
    chk("resume seconds", {9'b0, seconds_bin}, 16'd9);
    chk("resume valid", {15'b0, frame_valid}, 16'd1);

    // Reset mid-frame.
    dwell(4'b0111, pat_tab[4], 10);
    dwell(4'b1011, pat_tab[2], 10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst digits", digits, 16'hFFFF);
    chk("midrst valid", {15'b0, frame_valid}, 16'd0);
    chk("midrst minutes", {9'b0, minutes_bin}, 16'h007F);
    base_stb = stb_cnt;
    dwell(4'b1011, pat_tab[2], 10);
    dwell(4'b1101, pat_tab[0], 10);
    dwell(4'b1110, pat_tab[7], 10);
    dwell(4'hF, 7'h7F, 8);
    chk("midrst no frame", 16'(stb_cnt - base_stb), 16'd0);
    scan_round(4, 2, 0, 7, 10);
    chk("midrst new frame", digits, 16'h4207);

    // Randomized scanning.
    for (int r = 0; r < 200; r++) begin
      int kind, slot, n;
      logic [3:0] a;
      logic [6:0] s;
      kind = $urandom_range(0, 39);
      slot = 3 - (r % 4);
      if (kind == 3) slot = $urandom_range(0, 3);
      a = 4'hF ^ (4'h1 << slot);
      if (kind == 1) a = 4'($urandom);
      s = pat_tab[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) s = 7'($urandom);
      n = $urandom_range(2, 12);
      if (kind == 0) begin
        dwell(4'hF, 7'h7F, $urandom_range(55, 75));
      end else if (kind == 2) begin
        rst_n = 1'b0;
        dwell(a, s, 1);
        rst_n = 1'b1;
      end else begin
        dwell(a, s, n);
      end
    end
    dwell(4'hF, 7'h7F, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
